// File: rtl/i2c_pkg.sv
// Shared constants and FSM state type for the 24LC256-style I2C follower.
// The leader side may import CTRL_NIBBLE to build its control bytes.
package i2c_pkg;
  localparam logic [3:0] CTRL_NIBBLE  = 4'b1010;
  localparam logic [6:0] DEV_ADDR_DEF = {CTRL_NIBBLE, 3'b000};
  localparam logic       ACK_BIT      = 1'b0;
  localparam logic       NACK_BIT     = 1'b1;

  typedef enum logic [3:0] {
    IDLE, CTRL, ACK_CTRL, ADDR_HI, ACK_HI, ADDR_LO, ACK_LO,
    WR_DATA, ACK_WR, RD_DATA, RD_ACK, WAIT_STOP
  } state_e;
endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the system clock domain and flags SCL edges and START/STOP.
// Detect outputs are combinational off the synced value and one history register.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_s;

  // Idle bus is high on both lines, so reset to 1 to avoid a phantom edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  =  scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s &  scl_prev_q;
  assign start_det =  scl_s &  scl_prev_q &  sda_prev_q & ~sda_s;
  assign stop_det  =  scl_s &  scl_prev_q & ~sda_prev_q &  sda_s;
endmodule

// File: rtl/i2c_follower.sv
// I2C target emulating the 24LC256 control/address/data protocol over a small
// on-chip memory, with a registered local read port.
module i2c_follower
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = DEV_ADDR_DEF,
  parameter int         MEM_DEPTH = 64
) (
  input  logic                         CLK_50MHz,
  input  logic                         RESET,
  input  logic                         SCL,
  inout  wire                          SDA,
  input  logic [$clog2(MEM_DEPTH)-1:0] HOST_ADDR,
  output logic [7:0]                   HOST_DATA,
  output logic                         WR_STROBE,
  output logic                         BUSY
);
  localparam int PTR_W = $clog2(MEM_DEPTH);

  state_e           state_q;
  logic [2:0]       cnt_q;
  logic [7:0]       shift_q;
  logic [PTR_W-1:0] ptr_q;
  logic             rw_q, ack_drv_q, ld_q, sda_low_q, busy_q, we_q, strobe_q;
  logic [7:0]       host_q;
  logic [7:0]       mem_q [MEM_DEPTH];

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;
  logic [7:0] rx_byte, rd_byte;

  i2c_bus_sync u_sync (
    .clk       (CLK_50MHz),
    .rst_n     (RESET),
    .scl_i     (SCL),
    .sda_i     (SDA),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_s     (sda_s),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign rx_byte   = {shift_q[6:0], sda_s};
  assign rd_byte   = mem_q[ptr_q];
  assign SDA       = sda_low_q ? 1'b0 : 1'bz;
  assign HOST_DATA = host_q;
  assign WR_STROBE = strobe_q;
  assign BUSY      = busy_q;

  always_ff @(posedge CLK_50MHz or negedge RESET) begin
    if (!RESET) host_q <= 8'h00;
    else        host_q <= mem_q[HOST_ADDR];
  end

  always_ff @(posedge CLK_50MHz or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      ack_drv_q <= 1'b0;
      ld_q      <= 1'b0;
      sda_low_q <= 1'b0;
      busy_q    <= 1'b0;
      we_q      <= 1'b0;
      strobe_q  <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= 8'hFF;
    end else begin
      we_q     <= 1'b0;
      strobe_q <= we_q;
      // Bus conditions win over bit handling; a partial byte is simply dropped.
      if (start_det) begin
        state_q   <= CTRL;
        cnt_q     <= '0;
        ack_drv_q <= 1'b0;
        sda_low_q <= 1'b0;
      end else if (stop_det) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        ack_drv_q <= 1'b0;
        sda_low_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          CTRL, ADDR_HI, ADDR_LO, WR_DATA: if (scl_rise) begin
            shift_q <= rx_byte;
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              case (state_q)
                CTRL: begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    state_q <= ACK_CTRL;
                    rw_q    <= rx_byte[0];
                    busy_q  <= 1'b1;
                  end else begin
                    state_q <= WAIT_STOP;
                    busy_q  <= 1'b0;
                  end
                end
                ADDR_HI: state_q <= ACK_HI;
                ADDR_LO: begin
                  state_q <= ACK_LO;
                  ptr_q   <= rx_byte[PTR_W-1:0];
                end
                default: begin
                  mem_q[ptr_q] <= rx_byte;
                  we_q         <= 1'b1;
                  ptr_q        <= ptr_q + PTR_W'(1);
                  state_q      <= ACK_WR;
                end
              endcase
            end
          end
          // First fall pulls SDA low for the ACK, second fall ends the ACK slot.
          ACK_CTRL, ACK_HI, ACK_LO, ACK_WR: if (scl_fall) begin
            if (!ack_drv_q) begin
              ack_drv_q <= 1'b1;
              sda_low_q <= ~ACK_BIT;
            end else begin
              ack_drv_q <= 1'b0;
              cnt_q     <= '0;
              sda_low_q <= 1'b0;
              case (state_q)
                ACK_CTRL: begin
                  if (rw_q) begin
                    state_q   <= RD_DATA;
                    shift_q   <= rd_byte;
                    sda_low_q <= ~rd_byte[7];
                    ld_q      <= 1'b0;
                  end else begin
                    state_q <= ADDR_HI;
                  end
                end
                ACK_HI:  state_q <= ADDR_LO;
                default: state_q <= WR_DATA;
              endcase
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              if (ld_q) begin
                ld_q      <= 1'b0;
                shift_q   <= rd_byte;
                sda_low_q <= ~rd_byte[7];
              end else begin
                shift_q   <= {shift_q[6:0], 1'b0};
                sda_low_q <= ~shift_q[6];
              end
            end else if (scl_rise) begin
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) state_q <= RD_ACK;
            end
          end
          RD_ACK: begin
            if (scl_fall) begin
              sda_low_q <= 1'b0;
            end else if (scl_rise) begin
              if (sda_s == ACK_BIT) begin
                ptr_q   <= ptr_q + PTR_W'(1);
                ld_q    <= 1'b1;
                cnt_q   <= '0;
                state_q <= RD_DATA;
              end else begin
                state_q <= WAIT_STOP;
                busy_q  <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_follower.sv
// Bench for i2c_follower: bit-banged leader, transaction-level memory model,
// constant table for the page-write read-back, randomized transactions.
module tb_i2c_follower;
  logic       clk = 1'b0, rst_n = 1'b0, scl = 1'b1, m_low = 1'b0;
  logic [5:0] host_addr = '0;
  logic [7:0] host_data;
  logic       wr_strobe, busy;
  wire        sda_w;

  pullup (sda_w);
  assign sda_w = m_low ? 1'b0 : 1'bz;

  always #10 clk = ~clk;

  i2c_follower dut (
    .CLK_50MHz (clk),
    .RESET     (rst_n),
    .SCL       (scl),
    .SDA       (sda_w),
    .HOST_ADDR (host_addr),
    .HOST_DATA (host_data),
    .WR_STROBE (wr_strobe),
    .BUSY      (busy)
  );

  int         n_chk = 0, n_pass = 0, strobe_cnt = 0;
  logic [7:0] mmem [64];
  logic [5:0] mptr;
  logic [7:0] wbuf [8];

  typedef struct { logic [5:0] addr; logic [7:0] exp; } hv_t;
  hv_t tbl [6];

  always @(negedge clk) if (wr_strobe) strobe_cnt++;

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic half();  repeat (10) @(negedge clk); endtask
  task automatic q3();    repeat (3)  @(negedge clk); endtask

  // One SCL period; r is the line value sampled late in the high phase.
  task automatic xbit(input logic b, output logic r);
    m_low = ~b; half(); scl = 1'b1; half(); r = sda_w; scl = 1'b0; q3();
  endtask

  task automatic i2c_start();
    m_low = 1'b0; half(); scl = 1'b1; half(); m_low = 1'b1; half(); scl = 1'b0; q3();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; half(); scl = 1'b1; half(); m_low = 1'b0; half();
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) xbit(d[i], r);
    xbit(1'b1, ack);
  endtask

  task automatic rbyte(input logic ackb, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin xbit(1'b1, r); d[i] = r; end
    xbit(ackb, r);
  endtask

  task automatic host_rd(input logic [5:0] a, output logic [7:0] d);
    host_addr = a; @(negedge clk); @(negedge clk); d = host_data;
  endtask

  // START + write control + two address bytes; returns how many were not ACKed.
  task automatic set_addr(input logic [5:0] a, output int nk);
    logic k; logic [7:0] hi; logic [1:0] up;
    hi = 8'($urandom); up = 2'($urandom); nk = 0;
    i2c_start();
    wbyte(8'hA0, k); nk += int'(k);
    wbyte(hi, k);    nk += int'(k);
    wbyte({up, a}, k); nk += int'(k);
  endtask

  task automatic do_write(input logic [5:0] a, input int n);
    int nk, s0; logic k; logic [5:0] idx;
    s0 = strobe_cnt;
    set_addr(a, nk);
    for (int i = 0; i < n; i++) begin
      wbyte(wbuf[i], k); nk += int'(k);
      idx = a + 6'(i);
      mmem[idx] = wbuf[i];
    end
    i2c_stop();
    mptr = a + 6'(n);
    chk("wr_acks", nk, 0);
    chk("wr_strobes", strobe_cnt - s0, n);
  endtask

  // Model pointer: +1 after every ACKed read byte, unchanged after the final NACK.
  task automatic do_read(input logic rnd, input logic [5:0] a, input int n);
    int nk; logic k; logic [7:0] d;
    nk = 0;
    if (rnd) begin set_addr(a, nk); mptr = a; end
    i2c_start();
    wbyte(8'hA1, k); nk += int'(k);
    chk("rd_ctrl_acks", nk, 0);
    for (int i = 0; i < n; i++) begin
      rbyte(i == n - 1, d);
      chk("rd_byte", d, mmem[mptr]);
      if (i != n - 1) mptr++;
    end
    repeat (5) @(negedge clk);
    chk("nack_release", sda_w, 1'b1);
    chk("nack_busy", busy, 1'b0);
    i2c_stop();
  endtask

  initial begin
    logic k; logic [7:0] d; int s0, nk, nn, op; logic [5:0] a;
    for (int i = 0; i < 64; i++) mmem[i] = 8'hFF;
    mptr = '0;
    tbl = '{'{6'h05, 8'h11}, '{6'h06, 8'h22}, '{6'h07, 8'h33},
            '{6'h04, 8'hFF}, '{6'h08, 8'hFF}, '{6'h00, 8'hFF}};

    repeat (5) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_strobe", wr_strobe, 1'b0);
    chk("rst_host", host_data, 8'h00);
    chk("rst_sda", sda_w, 1'b1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Page write with BUSY timing around STOP
    s0 = strobe_cnt;
    i2c_start();
    wbyte(8'hA0, k); chk("pw_ctrl_ack", k, 1'b0);
    chk("pw_busy", busy, 1'b1);
    wbyte(8'h00, k); chk("pw_hi_ack", k, 1'b0);
    wbyte(8'h05, k); chk("pw_lo_ack", k, 1'b0);
    wbyte(8'h11, k); chk("pw_d0_ack", k, 1'b0);
    wbyte(8'h22, k); chk("pw_d1_ack", k, 1'b0);
    wbyte(8'h33, k); chk("pw_d2_ack", k, 1'b0);
    m_low = 1'b1; half(); scl = 1'b1; half(); m_low = 1'b0;
    repeat (2) @(negedge clk);
    chk("pw_busy_pre_stop", busy, 1'b1);
    @(negedge clk);
    chk("pw_busy_stop", busy, 1'b0);
    half();
    chk("pw_strobes", strobe_cnt - s0, 3);
    mmem[5] = 8'h11; mmem[6] = 8'h22; mmem[7] = 8'h33; mptr = 6'h08;
    for (int i = 0; i < 6; i++) begin
      host_rd(tbl[i].addr, d);
      chk("pw_host", d, tbl[i].exp);
    end

    // Random read 11,22,33 with ACK,ACK,NACK
    do_read(1'b1, 6'h05, 3);

    // Page wrap at the top of memory
    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
    do_write(6'h3E, 4);
    for (int i = 0; i < 4; i++) begin
      a = 6'h3E + 6'(i);
      host_rd(a, d); chk("wrap_host", d, mmem[a]);
    end

    // Address mismatch: no ACK anywhere, nothing written
    s0 = strobe_cnt; nn = 0;
    i2c_start();
    wbyte(8'hA2, k); chk("mis_nack", k, 1'b1);
    chk("mis_busy", busy, 1'b0);
    wbyte(8'h00, k); nn += int'(k);
    wbyte(8'h10, k); nn += int'(k);
    wbyte(8'hAB, k); nn += int'(k);
    chk("mis_ignored", nn, 3);
    i2c_stop();
    chk("mis_strobes", strobe_cnt - s0, 0);
    host_rd(6'h10, d); chk("mis_mem", d, mmem[6'h10]);

    // STOP after 5 data bits: byte dropped, pointer kept at 0x20
    s0 = strobe_cnt;
    set_addr(6'h20, nk); chk("ab_acks", nk, 0);
    xbit(1'b0, k); xbit(1'b1, k); xbit(1'b0, k); xbit(1'b1, k); xbit(1'b1, k);
    i2c_stop();
    mptr = 6'h20;
    chk("ab_strobes", strobe_cnt - s0, 0);
    chk("ab_busy", busy, 1'b0);
    host_rd(6'h20, d); chk("ab_mem", d, mmem[6'h20]);
    do_read(1'b0, 6'h00, 1);

    // Randomized transactions against the model
    for (int it = 0; it < 14; it++) begin
      op = int'($urandom_range(0, 2));
      a  = 6'($urandom);
      if (op == 0) begin
        nn = int'($urandom_range(1, 4));
        for (int i = 0; i < nn; i++) wbuf[i] = 8'($urandom);
        do_write(a, nn);
        a = 6'($urandom);
        host_rd(a, d); chk("rnd_host", d, mmem[a]);
      end else begin
        do_read(op == 1, a, int'($urandom_range(1, 3)));
      end
    end

    // Reset while the follower is driving a 0 data bit
    wbuf[0] = 8'h00;
    do_write(6'h30, 1);
    set_addr(6'h30, nk);
    i2c_start();
    wbyte(8'hA1, k); chk("rr_ctrl_ack", k, 1'b0);
    repeat (5) @(negedge clk);
    chk("rr_drive", sda_w, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rr_release", sda_w, 1'b1);
    for (int i = 0; i < 64; i++) mmem[i] = 8'hFF;
    mptr = '0;
    repeat (2) @(negedge clk);
    chk("rr_busy", busy, 1'b0);
    scl = 1'b1; m_low = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    host_rd(6'h30, d); chk("rr_mem", d, 8'hFF);
    do_read(1'b0, 6'h00, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
